regfile: RTL and testbench

// - General-purpose register file: final consumer of the write-back triple (wd, wreg, wdata) that the

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_rd_port.sv | 30 +++
 rtl/regfile.sv | 57 +++++
 tb/tb_regfile.sv | 120 ++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and named constants for the register file and the pipeline registers that feed it.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 32;

  typedef logic [DATA_W-1:0] reg_bus_t;
  typedef logic [ADDR_W-1:0] reg_addr_bus_t;

  localparam int            RegNum        = NUM_REGS;
  localparam reg_bus_t      ZeroWord      = '0;
  localparam reg_addr_bus_t NOPRegAddr    = '0;
  localparam logic          ReadEnable    = 1'b1;
  localparam logic          ReadDisable   = 1'b0;
  localparam logic          WriteEnable   = 1'b1;
  localparam logic          WriteDisable  = 1'b0;
  localparam logic          RstEnable     = 1'b1;
endpackage

// File: rtl/regfile_rd_port.sv
// One read port: reset, enable, zero index, range, same-cycle WB bypass, then stored value.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] array_data,
  output logic [DATA_W-1:0] rdata
);
  logic in_range;
  assign in_range = {1'b0, raddr} < (ADDR_W+1)'(NUM_REGS);

  always_comb begin
    rdata = '0;
    if (rst == RstEnable)           rdata = '0;
    else if (re == ReadDisable)     rdata = '0;
    else if (raddr == '0)           rdata = '0;
    else if (!in_range)             rdata = '0;
    else if (we == WriteEnable && raddr == waddr) rdata = wdata;
    else                            rdata = array_data;
  end
endmodule

// File: rtl/regfile.sv
// General-purpose register file: WB write port, two bypassed read ports, commit counter.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int CNT_W    = regfile_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [CNT_W-1:0]  commit_cnt
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] array1, array2;
  logic              commit;

  // Out-of-range indices never touch storage; the read port also masks them to zero.
  assign commit = (we == WriteEnable) && (waddr != '0) &&
                  ({1'b0, waddr} < (ADDR_W+1)'(NUM_REGS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      commit_cnt <= '0;
    end else if (commit) begin
      regs[waddr] <= wdata;
      commit_cnt  <= commit_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    array1 = '0;
    array2 = '0;
    if ({1'b0, raddr1} < (ADDR_W+1)'(NUM_REGS)) array1 = regs[raddr1];
    if ({1'b0, raddr2} < (ADDR_W+1)'(NUM_REGS)) array2 = regs[raddr2];
  end

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd1 (
    .rst(rst), .re(re1), .raddr(raddr1), .we(we), .waddr(waddr), .wdata(wdata),
    .array_data(array1), .rdata(rdata1)
  );

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd2 (
    .rst(rst), .re(re2), .raddr(raddr2), .we(we), .waddr(waddr), .wdata(wdata),
    .array_data(array2), .rdata(rdata2)
  );
endmodule

// File: tb/tb_regfile.sv
// Directed checks of regfile; a second instance with a 4-bit counter shares the stimulus.
module tb_regfile;
  logic        clk, rst, we, re1, re2;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata, rdata1, rdata2, commit_cnt;
  logic [31:0] rdata1_n, rdata2_n;
  logic [3:0]  commit_cnt_n;
  int          n_cmp, n_bad;

  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .commit_cnt(commit_cnt)
  );

  regfile #(.CNT_W(4)) dut_narrow (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1_n),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2_n), .commit_cnt(commit_cnt_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; idle();
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd7;
    #12;
    chk("reset_rd1", rdata1, 32'h0);
    chk("reset_rd2", rdata2, 32'h0);
    chk("reset_cnt", commit_cnt, 32'h0);

    // write r5, read it back next cycle
    @(negedge clk); rst = 1'b0;
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    @(negedge clk); idle(); re1 = 1'b1; raddr1 = 5'd5;
    #1;
    chk("wr_rd_r5", rdata1, 32'hDEADBEEF);
    chk("wr_cnt", commit_cnt, 32'd1);

    // enables gate each port independently
    re2 = 1'b0; raddr2 = 5'd5; #1;
    chk("re2_off", rdata2, 32'h0);
    chk("re2_off_rd1", rdata1, 32'hDEADBEEF);
    re2 = 1'b1; re1 = 1'b0; #1;
    chk("re1_off", rdata1, 32'h0);
    chk("re2_on", rdata2, 32'hDEADBEEF);

    // same-cycle bypass on both ports
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    #1;
    chk("byp_rd1", rdata1, 32'h12345678);
    chk("byp_rd2", rdata2, 32'h12345678);
    @(negedge clk); idle(); #1;
    chk("r7_stored", rdata1, 32'h12345678);
    chk("byp_cnt", commit_cnt, 32'd2);

    // register 0 is hardwired zero and writes to it are not counted
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    chk("r0_during", rdata1, 32'h0);
    chk("r0_during2", rdata2, 32'h0);
    @(negedge clk); idle(); #1;
    chk("r0_after", rdata1, 32'h0);
    chk("r0_cnt", commit_cnt, 32'd2);

    // async reset mid-run with loaded registers
    raddr1 = 5'd5; raddr2 = 5'd7; #1;
    chk("pre_rst_r5", rdata1, 32'hDEADBEEF);
    rst = 1'b1; #1;
    chk("rst_async_rd1", rdata1, 32'h0);
    chk("rst_async_rd2", rdata2, 32'h0);
    chk("rst_async_cnt", commit_cnt, 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_r5", rdata1, 32'h0);
    chk("post_rst_r7", rdata2, 32'h0);

    // 17 committed writes: 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = 5'((i % 31) + 1); wdata = 32'(i) + 32'h100;
    end
    @(negedge clk); idle();
    raddr1 = 5'd17; raddr2 = 5'd3; #1;
    chk("wrap_cnt32", commit_cnt, 32'd17);
    chk("wrap_cnt4", {28'h0, commit_cnt_n}, 32'd1);
    chk("burst_r17", rdata1, 32'h110);
    chk("burst_r3", rdata2, 32'h102);

    // reset held across a write edge: write lost, not counted
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
    #3 rst = 1'b1;
    @(negedge clk); rst = 1'b0; idle(); raddr1 = 5'd9; #1;
    chk("rst_wr_r9", rdata1, 32'h0);
    chk("rst_wr_cnt", commit_cnt, 32'h0);
    chk("rst_wr_cnt4", {28'h0, commit_cnt_n}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
